// File: rtl/demux_1ton_stream.sv
// ============================================================================
// demux_1ton_stream : registered 1-to-N valid/ready demultiplexer with
//                     optional packet lock and saturating drop counter
// Rev 1.0
// ============================================================================
`default_nettype none

module demux_1ton_stream #(
   parameter int WIDTH    = 8,
   parameter int N        = 4,
   parameter int SEL_W    = 2,
   parameter int PKT_LOCK = 1,
   parameter int CNT_W    = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WIDTH-1:0]     in_data_i,
   input  logic [SEL_W-1:0]     in_sel_i,
   input  logic                 in_last_i,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   output logic [N*WIDTH-1:0]   out_data_o,
   output logic [N-1:0]         out_valid_o,
   input  logic [N-1:0]         out_ready_i,
   output logic                 locked_o,
   output logic [CNT_W-1:0]     drop_cnt_o
);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_LOCK = 1'b1
   } state_t;

   localparam logic [SEL_W:0] c_num_lanes = (SEL_W+1)'(N);

   state_t             state_q,     state_d;
   logic               hold_valid_q, hold_valid_d;
   logic [WIDTH-1:0]   hold_data_q, hold_data_d;
   logic [SEL_W-1:0]   hold_sel_q,  hold_sel_d;
   logic [SEL_W-1:0]   lock_sel_q,  lock_sel_d;
   logic [CNT_W-1:0]   drop_cnt_q,  drop_cnt_d;

   logic               w_hold_rdy;
   logic [SEL_W-1:0]   w_eff_sel;
   logic               w_oor;
   logic               w_accept;
   logic               w_drain;

   always_comb begin
      w_hold_rdy = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (hold_sel_q == SEL_W'(k)) w_hold_rdy = out_ready_i[k];
      end
      in_ready_o = !hold_valid_q || w_hold_rdy;

      // Mid-packet the latched select overrides whatever in_sel carries.
      w_eff_sel = (PKT_LOCK != 0 && state_q == S_LOCK) ? lock_sel_q : in_sel_i;
      w_oor     = {1'b0, w_eff_sel} >= c_num_lanes;
      w_accept  = in_valid_i && in_ready_o;
      w_drain   = hold_valid_q && w_hold_rdy;

      state_d      = state_q;
      hold_valid_d = hold_valid_q;
      hold_data_d  = hold_data_q;
      hold_sel_d   = hold_sel_q;
      lock_sel_d   = lock_sel_q;
      drop_cnt_d   = drop_cnt_q;

      if (w_drain) hold_valid_d = 1'b0;

      if (w_accept && !w_oor) begin
         hold_valid_d = 1'b1;
         hold_data_d  = in_data_i;
         hold_sel_d   = w_eff_sel;
      end

      if (w_accept && w_oor && drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + CNT_W'(1);

      // A dropped first beat still locks so the rest of its packet is dropped too.
      if (PKT_LOCK != 0 && w_accept) begin
         case (state_q)
            S_IDLE: if (!in_last_i) begin
               state_d    = S_LOCK;
               lock_sel_d = in_sel_i;
            end
            S_LOCK: if (in_last_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         hold_valid_q <= 1'b0;
         hold_data_q  <= '0;
         hold_sel_q   <= '0;
         lock_sel_q   <= '0;
         drop_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         hold_valid_q <= hold_valid_d;
         hold_data_q  <= hold_data_d;
         hold_sel_q   <= hold_sel_d;
         lock_sel_q   <= lock_sel_d;
         drop_cnt_q   <= drop_cnt_d;
      end
   end

   generate
      for (genvar k = 0; k < N; k++) begin : g_lane
         localparam logic [SEL_W-1:0] c_lane = SEL_W'(k);
         assign out_valid_o[k] = hold_valid_q && (hold_sel_q == c_lane);
         assign out_data_o[k*WIDTH +: WIDTH] = out_valid_o[k] ? hold_data_q : '0;
      end
   endgenerate

   assign locked_o   = (state_q == S_LOCK);
   assign drop_cnt_o = drop_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_demux_1ton_stream.sv
// ============================================================================
// tb_demux_1ton_stream : scoreboard bench for demux_1ton_stream (lock, no-lock
//                        and 3-lane drop configurations)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_demux_1ton_stream;

   typedef struct {
      int         lane;
      logic [7:0] data;
   } exp_t;

   logic        clk;
   logic        rst;
   logic [7:0]  in_data;
   logic [1:0]  in_sel;
   logic        in_last;
   logic        in_valid;
   logic [3:0]  out_ready;

   logic        a_rdy, c_rdy, b_rdy;
   logic [31:0] a_od, c_od;
   logic [3:0]  a_ov, c_ov;
   logic        a_lk, c_lk, b_lk;
   logic [7:0]  a_dc, c_dc;

   logic [7:0]  b_data;
   logic [1:0]  b_sel;
   logic        b_last;
   logic        b_valid;
   logic [2:0]  b_ready;
   logic [23:0] b_od;
   logic [2:0]  b_ov;
   logic [1:0]  b_dc;

   exp_t qa[$];
   exp_t qc[$];
   exp_t ea, ec;
   int   n_vec;
   int   n_bad;

   // A: packet lock on, C: lock off; both share one stimulus stream.
   demux_1ton_stream #(.WIDTH(8), .N(4), .SEL_W(2), .PKT_LOCK(1), .CNT_W(8)) u_a (
      .clk(clk), .rst(rst), .in_data_i(in_data), .in_sel_i(in_sel), .in_last_i(in_last),
      .in_valid_i(in_valid), .in_ready_o(a_rdy), .out_data_o(a_od), .out_valid_o(a_ov),
      .out_ready_i(out_ready), .locked_o(a_lk), .drop_cnt_o(a_dc));

   demux_1ton_stream #(.WIDTH(8), .N(4), .SEL_W(2), .PKT_LOCK(0), .CNT_W(8)) u_c (
      .clk(clk), .rst(rst), .in_data_i(in_data), .in_sel_i(in_sel), .in_last_i(in_last),
      .in_valid_i(in_valid), .in_ready_o(c_rdy), .out_data_o(c_od), .out_valid_o(c_ov),
      .out_ready_i(out_ready), .locked_o(c_lk), .drop_cnt_o(c_dc));

   demux_1ton_stream #(.WIDTH(8), .N(3), .SEL_W(2), .PKT_LOCK(1), .CNT_W(2)) u_b (
      .clk(clk), .rst(rst), .in_data_i(b_data), .in_sel_i(b_sel), .in_last_i(b_last),
      .in_valid_i(b_valid), .in_ready_o(b_rdy), .out_data_o(b_od), .out_valid_o(b_ov),
      .out_ready_i(b_ready), .locked_o(b_lk), .drop_cnt_o(b_dc));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic push(input int lane_a, input int lane_c, input logic [7:0] d);
      exp_t e;
      e.data = d;
      e.lane = lane_a;
      qa.push_back(e);
      e.lane = lane_c;
      qc.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every completed output handshake is matched against the queues.
   always @(negedge clk) begin
      if (!rst) begin
         for (int k = 0; k < 4; k++) begin
            if (a_ov[k] && out_ready[k]) begin
               if (qa.size() == 0) begin
                  n_vec++; n_bad++;
                  $display("FAIL A_unexpected: lane %0d data %0h, required no beat", k, a_od);
               end else begin
                  ea = qa.pop_front();
                  chk("A_out_valid", 32'(a_ov), 32'(1) << ea.lane);
                  chk("A_out_data", a_od, 32'(ea.data) << (8 * ea.lane));
               end
            end
            if (c_ov[k] && out_ready[k]) begin
               if (qc.size() == 0) begin
                  n_vec++; n_bad++;
                  $display("FAIL C_unexpected: lane %0d data %0h, required no beat", k, c_od);
               end else begin
                  ec = qc.pop_front();
                  chk("C_out_valid", 32'(c_ov), 32'(1) << ec.lane);
                  chk("C_out_data", c_od, 32'(ec.data) << (8 * ec.lane));
               end
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [1:0] p_sel  [3];
      logic       p_last [3];
      n_vec = 0;
      n_bad = 0;

      // Reset with traffic present on the inputs
      rst = 1'b1; in_valid = 1'b1; in_data = 8'hFF; in_sel = 2'd1; in_last = 1'b0;
      out_ready = 4'hF;
      b_valid = 1'b1; b_data = 8'hEE; b_sel = 2'd3; b_last = 1'b0; b_ready = 3'b111;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(a_ov), 32'h0);
      chk("rst_in_ready", 32'(a_rdy), 32'h1);
      chk("rst_drop_cnt", 32'(a_dc), 32'h0);
      chk("rst_locked", 32'(a_lk), 32'h0);
      chk("rst_b_drop_cnt", 32'(b_dc), 32'h0);
      chk("rst_b_out_valid", 32'(b_ov), 32'h0);
      rst = 1'b0; in_valid = 1'b0; b_valid = 1'b0;
      tick();

      // Routing at full throughput
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_data = 8'(8'hA0 + i); in_sel = 2'(i); in_last = 1'b1;
         push(i, i, 8'(8'hA0 + i));
         #1;
         chk("route_in_ready", 32'(a_rdy), 32'h1);
         tick();
      end
      in_valid = 1'b0;
      tick();

      // Backpressure on lane 2 while the next beat waits
      out_ready = 4'b1011;
      in_valid = 1'b1; in_data = 8'h55; in_sel = 2'd2; in_last = 1'b1;
      push(2, 2, 8'h55);
      tick();
      in_data = 8'h66;
      push(2, 2, 8'h66);
      repeat (3) begin
         #1;
         chk("stall_in_ready", 32'(a_rdy), 32'h0);
         chk("stall_out_valid", 32'(a_ov), 32'h4);
         chk("stall_out_data", a_od, 32'h0055_0000);
         tick();
      end
      out_ready = 4'hF;
      #1;
      chk("release_in_ready", 32'(a_rdy), 32'h1);
      tick();
      in_valid = 1'b0;
      tick();

      // Three-beat packet: A stays on lane 1, C follows every select
      p_sel[0] = 2'd1; p_sel[1] = 2'd3; p_sel[2] = 2'd0;
      p_last[0] = 1'b0; p_last[1] = 1'b0; p_last[2] = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_data = 8'(8'hB0 + i); in_sel = p_sel[i]; in_last = p_last[i];
         push(1, int'(p_sel[i]), 8'(8'hB0 + i));
         tick();
         chk("pkt_locked", 32'(a_lk), (i < 2) ? 32'h1 : 32'h0);
         chk("pkt_c_locked", 32'(c_lk), 32'h0);
      end
      in_data = 8'hC0; in_sel = 2'd3; in_last = 1'b1;
      push(3, 3, 8'hC0);
      tick();
      chk("single_locked", 32'(a_lk), 32'h0);
      in_valid = 1'b0;
      tick();

      // Reset while locked with a beat held
      out_ready = 4'h0;
      in_valid = 1'b1; in_data = 8'hD0; in_sel = 2'd2; in_last = 1'b0;
      tick();
      in_valid = 1'b0;
      chk("mid_locked", 32'(a_lk), 32'h1);
      chk("mid_held_valid", 32'(a_ov), 32'h4);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mrst_locked", 32'(a_lk), 32'h0);
      chk("mrst_out_valid", 32'(a_ov), 32'h0);
      chk("mrst_c_out_valid", 32'(c_ov), 32'h0);
      out_ready = 4'hF;
      in_valid = 1'b1; in_data = 8'hD1; in_sel = 2'd0; in_last = 1'b1;
      push(0, 0, 8'hD1);
      tick();
      in_valid = 1'b0;
      repeat (2) tick();

      // Drops on the 3-lane instance: locked packet, then saturation
      b_valid = 1'b1; b_data = 8'h11; b_sel = 2'd3; b_last = 1'b0;
      #1;
      chk("drop_in_ready", 32'(b_rdy), 32'h1);
      tick();
      chk("drop_out_valid", 32'(b_ov), 32'h0);
      chk("drop_locked", 32'(b_lk), 32'h1);
      b_data = 8'h12; b_sel = 2'd0; b_last = 1'b1;
      #1;
      chk("drop2_in_ready", 32'(b_rdy), 32'h1);
      tick();
      chk("drop2_out_valid", 32'(b_ov), 32'h0);
      chk("drop2_cnt", 32'(b_dc), 32'h2);
      chk("drop2_locked", 32'(b_lk), 32'h0);
      b_sel = 2'd3; b_last = 1'b1;
      repeat (4) tick();
      chk("drop_sat_cnt", 32'(b_dc), 32'h3);
      chk("drop_sat_out_valid", 32'(b_ov), 32'h0);
      b_data = 8'h77; b_sel = 2'd1;
      tick();
      b_valid = 1'b0;
      chk("b_route_valid", 32'(b_ov), 32'h2);
      chk("b_route_data", 32'(b_od), 32'h0000_7700);
      chk("b_route_cnt", 32'(b_dc), 32'h3);
      tick();

      chk("A_queue_empty", 32'(qa.size()), 32'h0);
      chk("C_queue_empty", 32'(qc.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
